seg7_triple_display: RTL and testbench
======================================

Name: seg7_triple_display

Overview:
- Output stage directly downstream of `top`.
- Consumes the three 6-bit values `top` produces (value1, value2, value3) and shows each as two decimal digits on a 6-digit multiplexed seven-segment display.
- Each captured value is converted to BCD with a sequential double-dabble.
- Digits are scanned at a fixed refresh rate.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit stays enabled; must be ≥2.
- CNT_W, 16: prescaler counter width; must satisfy 2**CNT_W ≥ REFRESH_DIV.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- value1  input  6  first value, unsigned 0..63.
- value2  input  6  second value, unsigned 0..63.
- value3  input  6  third value, unsigned 0..63.
- load  input  1  single-cycle strobe: capture the three values and start conversion.
- busy  output  1  high while a conversion is in progress.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held 1 (off).
- an  output  6  digit enables, active-low, one-hot-zero.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. rst has priority over every other input, including a simultaneous load.
- Reset state:
  - FSM in IDLE, busy=0.
  - All display registers 0.
  - Digit index 0, prescaler 0.
  - an=6'b111110; seg=7'b1000000 (glyph "0"); dp=1.
- Digit mapping:
  - an[0] = value3 ones, an[1] = value3 tens.
  - an[2] = value2 ones, an[3] = value2 tens.
  - an[4] = value1 ones, an[5] = value1 tens.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE, load=1 at edge E0: capture value1..3 into shift registers, clear BCD accumulators, step counter=0, go to SHIFT. busy=1 after E0.
  - SHIFT, edges E1..E6: per value, in parallel:
    - ones≥5 → ones+3; tens≥5 → tens+3 (correction before shift);
    - then shift {tens[2:0], ones[3:0], bin[5:0]} left by 1.
    - After the 6th shift, go to COMMIT.
  - COMMIT, edge E7: copy the six BCD digits into the display registers, go to IDLE. busy=0 after E7.
  - busy is high for exactly 7 cycles. New digits appear on the display from E7.
- Widths: tens field 3 bits (max 6), ones field 4 bits (max 9). Input 63 yields 6/3.
- load while busy=1: ignored, no queuing. The display registers keep old digits until COMMIT, so no partial values are ever shown.
- rst during SHIFT or COMMIT: conversion aborted, display registers cleared to zero, IDLE.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1. On the terminal count it wraps to 0 and the digit index increments, 5 wraps to 0.
  - Each an bit is low for exactly REFRESH_DIV cycles.
  - Scanning is independent of the FSM and never stalls.
- seg/an are registered: both update on the same edge, so there is no glitch between digit and glyph.
- Glyphs for 0..9 are active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Optional Feature:
- SEG7_LZ_BLANK_EN, defined: a tens digit equal to 0 drives seg=7'b1111111 (blank) while its an bit is active; ones digits are never blanked.
- Undefined: a tens digit of 0 shows glyph "0".

Decomposition:
- Shared package seg7_pkg holds:
  - the FSM state enum (IDLE/SHIFT/COMMIT);
  - the glyph constants for 0..9 and SEG_BLANK;
  - the digit-count constant 6.
- One natural sub-module, bcd_dabble6: a sequential 6-bit binary to 2-digit BCD step unit with start, step and done. It is instantiated three times and driven by the shared FSM.

Test Plan (REFRESH_DIV=4 in simulation):
1. Reset: assert rst 2 cycles → busy=0, an=111110, seg=1000000, dp=1. All six digits read 0 over one full scan.
2. Load 1/42/63:
   - Pulse load with value1=1, value2=42, value3=63 → busy high exactly 7 cycles.
   - Afterwards the scan shows an[5..0] = 0,1,4,2,6,3.
   - seg at an[3] = 0011001; seg at an[0] = 0110000.
3. Load while busy: pulse load with 9/9/9 two cycles after test 2's load → ignored. The display still shows 01 42 63 and busy drops at the original E7.
4. Scan timing: free-run 30 cycles → an sequence 111110, 111101, 111011, 110111, 101111, 011111, 111110, each held exactly 4 cycles, always exactly one bit low.
5. Reset mid-conversion: load 63/63/63, then assert rst at E3 → busy=0 the next cycle, all digits 0, and no 6/3 glyph ever appears.
6. SEG7_LZ_BLANK_EN defined: load 5/0/10 → an[5]=1111111, an[4]=0010010, an[3]=1111111, an[2]=1000000, an[1]=1111001, an[0]=1000000.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the triple two-digit seven-segment display:
// conversion FSM states, active-low {g..a} glyphs and the digit count.
package seg7_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StCommit = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 6;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal codes cannot occur; they map to a blank digit.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bcd_dabble6.sv
// Sequential double-dabble: 6-bit binary to tens (3 bits) / ones (4 bits).
// start loads the operand, each step does one correct-then-shift, and
// done flags the step that completes the sixth shift.
module bcd_dabble6 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step,
    input  logic [5:0] bin,
    output logic [2:0] tens,
    output logic [3:0] ones,
    output logic       done
);

    logic [5:0]  bin_q;
    logic [2:0]  tens_q;
    logic [3:0]  ones_q;
    logic [2:0]  cnt_q;
    logic [2:0]  tens_adj;
    logic [3:0]  ones_adj;
    logic [12:0] shifted;

    // Add-3 correction on each BCD field, then shift the whole vector left.
    always_comb begin
        tens_adj = (tens_q >= 3'd5) ? tens_q + 3'd3 : tens_q;
        ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
        shifted  = {tens_adj, ones_adj, bin_q} << 1;
    end

    // Operand, accumulators and step count.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            tens_q <= '0;
            ones_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            bin_q  <= bin;
            tens_q <= '0;
            ones_q <= '0;
            cnt_q  <= '0;
        end else if (step) begin
            tens_q <= shifted[12:10];
            ones_q <= shifted[9:6];
            bin_q  <= shifted[5:0];
            cnt_q  <= cnt_q + 3'd1;
        end
    end

    assign done = step && (cnt_q == 3'd5);
    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/seg7_triple_display.sv
// Shows three 6-bit values as two decimal digits each on a six-digit
// multiplexed, active-low seven-segment display. A load strobe starts a
// 6-step BCD conversion; results are committed to the display at once.
// Optional build macro SEG7_LZ_BLANK_EN blanks tens digits equal to zero.
module seg7_triple_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] value1,
    input  logic [5:0] value2,
    input  logic [5:0] value3,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

    state_t state_q;
    logic   busy_q;
    logic   start;
    logic   step;

    // Unit 0 converts value3, unit 2 converts value1 (digit order on display).
    logic [2:0][5:0] vals;
    logic [2:0][2:0] tens;
    logic [2:0][3:0] ones;
    logic [2:0]      done;

    logic [NUM_DIGITS-1:0][3:0] disp_q;
    logic [NUM_DIGITS-1:0][3:0] disp_d;
    logic [CNT_W-1:0]           presc_q;
    logic [CNT_W-1:0]           presc_d;
    logic [2:0]                 idx_q;
    logic [2:0]                 idx_d;
    logic [3:0]                 digit;
    logic [6:0]                 seg_q;
    logic [6:0]                 seg_d;
    logic [5:0]                 an_q;
    logic [5:0]                 an_d;

    assign vals  = {value1, value2, value3};
    assign start = (state_q == StIdle) && load;
    assign step  = (state_q == StShift);

    for (genvar u = 0; u < 3; u++) begin : g_dabble
        bcd_dabble6 u_dabble (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .step  (step),
            .bin   (vals[u]),
            .tens  (tens[u]),
            .ones  (ones[u]),
            .done  (done[u])
        );
    end

    // Conversion control: IDLE -> SHIFT (6 steps) -> COMMIT -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        state_q <= StShift;
                        busy_q  <= 1'b1;
                    end
                end
                StShift: begin
                    if (&done) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next display contents, prescaler and digit index, plus the glyph for
    // the digit that becomes active; seg and an are registered together.
    always_comb begin
        disp_d = disp_q;
        if (state_q == StCommit) begin
            for (int i = 0; i < 3; i++) begin
                disp_d[2*i]   = ones[i];
                disp_d[2*i+1] = {1'b0, tens[i]};
            end
        end

        presc_d = presc_q + CNT_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end

        digit = disp_d[idx_d];
        seg_d = bcd_to_seg(digit);
`ifdef SEG7_LZ_BLANK_EN
        // Odd digit positions hold tens.
        if (idx_d[0] && (digit == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
`endif
        an_d = ~(6'b000001 << idx_d);
    end

    // Display registers and free-running scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_0;
            an_q    <= 6'b111110;
        end else begin
            disp_q  <= disp_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign busy = busy_q;
    assign seg  = seg_q;
    assign an   = an_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_seg7_triple_display.sv
// Self-checking bench for seg7_triple_display with a short refresh period.
// Expected display contents are queued when a load or reset is driven and
// compared against a full captured scan once the DUT settles.
module tb_seg7_triple_display;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [5:0] value1;
    logic [5:0] value2;
    logic [5:0] value3;
    logic       busy;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;

    int checks = 0;
    int errors = 0;
    int bad_glyph = 0;
    bit watch = 1'b0;
    logic [41:0] exp_q[$];

    seg7_triple_display #(
        .REFRESH_DIV (DIV),
        .CNT_W       (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .value1 (value1),
        .value2 (value2),
        .value3 (value3),
        .load   (load),
        .busy   (busy),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    always #5 clk = ~clk;

    // Count any 3 or 6 glyph while watching an aborted 63/63/63 conversion.
    always @(negedge clk) begin
        if (watch && (seg == 7'b0110000 || seg == 7'b0000010)) bad_glyph++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] expect_segs(input int v1, input int v2, input int v3);
        int d[6];
        logic [41:0] r;
        d[0] = v3 % 10; d[1] = v3 / 10;
        d[2] = v2 % 10; d[3] = v2 / 10;
        d[4] = v1 % 10; d[5] = v1 / 10;
        for (int i = 0; i < 6; i++) begin
            r[i*7 +: 7] = ref_glyph(d[i]);
`ifdef SEG7_LZ_BLANK_EN
            if ((i % 2 == 1) && (d[i] == 0)) r[i*7 +: 7] = 7'b1111111;
`endif
        end
        return r;
    endfunction

    task automatic capture_scan(output logic [41:0] segs, output int busy_seen);
        segs = 'x;
        busy_seen = 0;
        for (int c = 0; c < 6 * DIV + 2; c++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            for (int i = 0; i < 6; i++) begin
                if (an == ~(6'b000001 << i)) segs[i*7 +: 7] = seg;
            end
        end
    endtask

    task automatic pop_and_compare(input string tag);
        logic [41:0] got;
        logic [41:0] exp;
        int bs;
        check_eq({tag, "_pending"}, exp_q.size(), 1);
        exp = 'x;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        capture_scan(got, bs);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("%s_seg_an%0d", tag, i), got[i*7 +: 7], exp[i*7 +: 7]);
        end
        check_eq({tag, "_busy_idle"}, bs, 0);
    endtask

    // Pulse load, optionally re-pulse load with 9/9/9 two cycles later, and
    // count how many cycles busy stays high (bounded).
    task automatic run_load(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                            input bit overlap, output int busy_cycles);
        @(negedge clk);
        value1 = a; value2 = b; value3 = c; load = 1'b1;
        exp_q.push_back(expect_segs(a, b, c));
        @(negedge clk);
        load = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            busy_cycles++;
            if (overlap && k == 1) begin
                value1 = 6'd9; value2 = 6'd9; value3 = 6'd9; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        int bc;
        int run;
        int bad_before;
        bit first;
        logic [5:0] prev;

        // Test 1: reset state and an all-zero scan.
        rst = 1'b1; load = 1'b0; value1 = '0; value2 = '0; value3 = '0;
        exp_q.push_back(expect_segs(0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_an", an, 6'b111110);
        check_eq("rst_seg", seg, 7'b1000000);
        check_eq("rst_dp", dp, 1'b1);
        rst = 1'b0;
        pop_and_compare("reset");

        // Test 2: convert 1/42/63.
        run_load(6'd1, 6'd42, 6'd63, 1'b0, bc);
        check_eq("load_busy_len", bc, 7);
        pop_and_compare("load_1_42_63");

        // Test 3: second load during conversion is ignored.
        run_load(6'd1, 6'd42, 6'd63, 1'b1, bc);
        check_eq("overlap_busy_len", bc, 7);
        pop_and_compare("overlap_ignored");
        check_eq("dp_idle", dp, 1'b1);

        // Test 4: scan order, hold time, exactly one digit enabled.
        @(negedge clk);
        prev = an; run = 1; first = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check_eq("an_one_low", $countones(~an), 1);
            if (an == prev) begin
                run++;
            end else begin
                if (!first) check_eq("an_hold", run, DIV);
                check_eq("an_next", an, {prev[4:0], prev[5]});
                first = 1'b0;
                run = 1;
                prev = an;
            end
        end

        // Test 5: reset at E3 of a 63/63/63 conversion.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bad_before = bad_glyph;
        watch = 1'b1;
        @(negedge clk);
        value1 = 6'd63; value2 = 6'd63; value3 = 6'd63; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        check_eq("mid_busy_before_rst", busy, 1'b1);
        @(negedge clk); rst = 1'b1;
        exp_q.push_back(expect_segs(0, 0, 0));
        @(negedge clk);
        check_eq("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        pop_and_compare("mid_rst");
        repeat (10) @(negedge clk);
        watch = 1'b0;
        check_eq("no_63_glyph", bad_glyph - bad_before, 0);

        // Test 6: 5/0/10 exercises zero tens digits (blanked when enabled).
        run_load(6'd5, 6'd0, 6'd10, 1'b0, bc);
        check_eq("lz_busy_len", bc, 7);
        pop_and_compare("load_5_0_10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
